// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the unified memory port: one transaction in
// flight at a time, with a response watchdog that synthesises error responses.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 64,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 c0_req,
   input  logic                 c0_we,
   input  logic [ADDR_W-1:0]    c0_addr,
   input  logic [DATA_W-1:0]    c0_wdata,
   output logic                 c0_gnt,
   output logic                 c0_rvalid,
   output logic [DATA_W-1:0]    c0_rdata,
   output logic                 c0_err,
   input  logic                 c1_req,
   input  logic                 c1_we,
   input  logic [ADDR_W-1:0]    c1_addr,
   input  logic [DATA_W-1:0]    c1_wdata,
   output logic                 c1_gnt,
   output logic                 c1_rvalid,
   output logic [DATA_W-1:0]    c1_rdata,
   output logic                 c1_err,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic                 mem_ready,
   input  logic                 mem_rvalid,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 busy,
   output logic                 owner,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam bit                WDOG_EN  = (TIMEOUT != 0);
   localparam int                TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(WDOG_EN ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

   state_t              state, state_nx;
   logic                prio;
   logic [TMR_W-1:0]    timer;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;

   logic                any_req;
   logic                pick;
   logic                issue_done;
   logic                rsp_ok;
   logic                tmo;

   // With both ports requesting the preferred port wins, otherwise the lone requester.
   assign any_req    = c0_req | c1_req;
   assign pick       = (c0_req & c1_req) ? prio : c1_req;
   assign issue_done = (state == ISSUE) & mem_ready;
   assign rsp_ok     = (state == WAIT_RSP) & mem_rvalid;
   assign tmo        = WDOG_EN & (state == WAIT_RSP) & ~mem_rvalid & (timer == TMR_LAST);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (any_req)       state_nx = ISSUE;
         ISSUE:    if (mem_ready)     state_nx = WAIT_RSP;
         WAIT_RSP: if (rsp_ok | tmo)  state_nx = IDLE;
         default:                     state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio      <= 1'b0;
         owner     <= 1'b0;
         timer     <= '0;
         err_count <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         if ((state == IDLE) && any_req) begin
            owner     <= pick;
            lat_we    <= pick ? c1_we    : c0_we;
            lat_addr  <= pick ? c1_addr  : c0_addr;
            lat_wdata <= pick ? c1_wdata : c0_wdata;
         end
         if (issue_done) begin
            prio  <= ~owner;
            timer <= '0;
         end else if (state == WAIT_RSP) begin
            timer <= timer + TMR_W'(1);
         end
         if (tmo && (err_count != '1))
            err_count <= err_count + ERR_CNT_W'(1);
      end
   end

   // Responses and grants are combinational so the requester sees them in the memory's cycle.
   always_comb begin
      mem_req   = (state == ISSUE);
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == ISSUE) begin
         mem_we    = lat_we;
         mem_addr  = lat_addr;
         mem_wdata = lat_wdata;
      end
      c0_gnt    = issue_done & ~owner;
      c1_gnt    = issue_done &  owner;
      c0_rvalid = (rsp_ok | tmo) & ~owner;
      c1_rvalid = (rsp_ok | tmo) &  owner;
      c0_err    = tmo & ~owner;
      c1_err    = tmo &  owner;
      c0_rdata  = (rsp_ok & ~owner) ? mem_rdata : '0;
      c1_rdata  = (rsp_ok &  owner) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model is checked
// every cycle, with literal expectations at the key points of each scenario.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk, reset;
   logic          c0_req, c0_we, c1_req, c1_we;
   logic [AW-1:0] c0_addr, c1_addr;
   logic [DW-1:0] c0_wdata, c1_wdata;
   logic          c0_gnt, c0_rvalid, c0_err, c1_gnt, c1_rvalid, c1_err;
   logic [DW-1:0] c0_rdata, c1_rdata;
   logic          mem_req, mem_we, mem_ready, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          busy, owner;
   logic [7:0]    err_count;

   int n_chk = 0;
   int n_fail = 0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .ERR_CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata), .c0_err(c0_err),
      .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata), .c1_err(c1_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: an optional pending transaction, whether memory has
   // accepted it, and how many response cycles have elapsed since acceptance.
   bit          m_have, m_acc, m_prio, m_own, m_we;
   int          m_wait, m_errs;
   logic [31:0] m_addr, m_wdata;

   always @(negedge clk) begin
      logic issue, waiting, tmo, rsp, win;
      if (reset) begin
         m_have = 0; m_acc = 0; m_prio = 0; m_own = 0; m_we = 0;
         m_wait = 0; m_errs = 0; m_addr = 0; m_wdata = 0;
         chk("rst_outs", {mem_req, mem_we, c0_gnt, c1_gnt, c0_rvalid, c1_rvalid,
                          c0_err, c1_err, busy, owner}, 0);
         chk("rst_data", {mem_addr, mem_wdata, c0_rdata, c1_rdata}, 0);
         chk("rst_errcnt", err_count, 0);
      end else begin
         issue   = m_have && !m_acc;
         waiting = m_have && m_acc;
         tmo     = waiting && (m_wait == TO) && !mem_rvalid;
         rsp     = waiting && (mem_rvalid || tmo);
         chk("m_mem_req",  mem_req, issue);
         chk("m_mem_we",   mem_we,    issue ? m_we    : 1'b0);
         chk("m_mem_addr", mem_addr,  issue ? m_addr  : 32'd0);
         chk("m_mem_wdat", mem_wdata, issue ? m_wdata : 32'd0);
         chk("m_gnt",    {c1_gnt, c0_gnt},
             (issue && mem_ready) ? (m_own ? 2'b10 : 2'b01) : 2'b00);
         chk("m_rvalid", {c1_rvalid, c0_rvalid}, rsp ? (m_own ? 2'b10 : 2'b01) : 2'b00);
         chk("m_err",    {c1_err, c0_err},       tmo ? (m_own ? 2'b10 : 2'b01) : 2'b00);
         chk("m_rdata0", c0_rdata, (rsp && !m_own && mem_rvalid) ? mem_rdata : 32'd0);
         chk("m_rdata1", c1_rdata, (rsp &&  m_own && mem_rvalid) ? mem_rdata : 32'd0);
         chk("m_busy",   busy, m_have);
         chk("m_owner",  owner, m_own);
         chk("m_errcnt", err_count, m_errs[7:0]);
         if (!m_have) begin
            if (c0_req || c1_req) begin
               win     = (c0_req && c1_req) ? m_prio : c1_req;
               m_own   = win;
               m_we    = win ? c1_we    : c0_we;
               m_addr  = win ? c1_addr  : c0_addr;
               m_wdata = win ? c1_wdata : c0_wdata;
               m_have  = 1; m_acc = 0;
            end
         end else if (issue) begin
            if (mem_ready) begin m_acc = 1; m_wait = 1; m_prio = !m_own; end
         end else if (rsp) begin
            m_have = 0; m_acc = 0;
            if (tmo && m_errs < 255) m_errs++;
         end else begin
            m_wait++;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input bit p, input bit rq, input bit we, input logic [31:0] a, input logic [31:0] wd);
      if (p) begin c1_req = rq; c1_we = we; c1_addr = a; c1_wdata = wd; end
      else   begin c0_req = rq; c0_we = we; c0_addr = a; c0_wdata = wd; end
   endtask

   // Single transaction from IDLE; rsp_at = response-cycle index of mem_rvalid, 0 = never.
   task automatic txn(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input int rsp_at, input logic [31:0] rd);
      int last;
      last = (rsp_at == 0) ? TO : rsp_at;
      drive(p, 1, we, a, wd);
      mem_ready = 1;
      tick();
      @(negedge clk);
      chk("txn_gnt",  p ? c1_gnt : c0_gnt, 1);
      chk("txn_addr", mem_addr, a);
      chk("txn_we",   mem_we, we);
      tick();
      drive(p, 0, 0, 0, 0);
      mem_ready = 0;
      for (int w = 1; w <= last; w++) begin
         mem_rvalid = (w == rsp_at);
         mem_rdata  = (w == rsp_at) ? rd : 32'h0;
         @(negedge clk);
         if (w < last) chk("txn_early_rv", p ? c1_rvalid : c0_rvalid, 0);
         else begin
            chk("txn_rvalid", p ? c1_rvalid : c0_rvalid, 1);
            chk("txn_err",    p ? c1_err    : c0_err,    rsp_at == 0);
            chk("txn_rdata",  p ? c1_rdata  : c0_rdata,  (rsp_at == 0) ? 32'h0 : rd);
         end
         tick();
      end
      mem_rvalid = 0;
      mem_rdata  = 0;
   endtask

   bit seq[$];

   initial begin
      reset = 1;
      drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      tick(); tick();
      reset = 0;
      tick();

      // Single core read: gnt at cycle 1, rvalid with data at cycle 3.
      txn(0, 0, 32'h10, 0, 2, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_idle", busy, 0);

      // Simultaneous requests straight after reset: core first, then loader write.
      reset = 1; tick(); reset = 0;
      drive(0, 1, 0, 32'h0, 0);
      drive(1, 1, 1, 32'h100, 32'h55);
      mem_ready = 1;
      tick();
      @(negedge clk);
      chk("t2_c0_gnt", c0_gnt, 1);
      chk("t2_c1_gnt", c1_gnt, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      mem_rvalid = 1; mem_rdata = 32'h1234;
      @(negedge clk);
      chk("t2_c0_rv", c0_rvalid, 1);
      tick();
      mem_rvalid = 0; mem_rdata = 0;
      tick();
      @(negedge clk);
      chk("t2_c1_gnt", c1_gnt, 1);
      chk("t2_mem", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h100, 32'h55});
      chk("t2_owner", owner, 1);
      tick();
      drive(1, 0, 0, 0, 0);
      mem_rvalid = 1;
      @(negedge clk);
      chk("t2_c1_rv", c1_rvalid, 1);
      tick();
      mem_rvalid = 0;

      // Fairness: both held, memory always ready/responding; owner must alternate from 0.
      drive(0, 1, 0, 32'h20, 0);
      drive(1, 1, 0, 32'h24, 0);
      mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h5A;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (c0_gnt) seq.push_back(1'b0);
         if (c1_gnt) seq.push_back(1'b1);
         tick();
      end
      drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
      mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
      chk("fair_len", seq.size(), 4);
      for (int i = 0; i < 4; i++) chk("fair_owner", (i < seq.size()) ? seq[i] : 1'bx, i % 2);
      tick();

      // Backpressure on a loader write; the loader drops req mid-ISSUE.
      drive(1, 1, 1, 32'h200, 32'hA5A5);
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold", {mem_req, mem_addr, mem_wdata, c1_gnt}, {1'b1, 32'h200, 32'hA5A5, 1'b0});
         tick();
         if (k == 1) drive(1, 0, 0, 0, 0);
      end
      mem_ready = 1;
      @(negedge clk);
      chk("bp_gnt", c1_gnt, 1);
      tick();
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h99;
      @(negedge clk);
      chk("bp_rdata", c1_rdata, 32'h99);
      tick();
      mem_rvalid = 0; mem_rdata = 0;

      // Watchdog: error on the 8th response cycle, then normal service, then a tie.
      txn(0, 0, 32'h40, 0, 0, 0);
      @(negedge clk);
      chk("to_errcnt", err_count, 1);
      chk("to_busy", busy, 0);
      tick();
      txn(0, 0, 32'h44, 0, 1, 32'hCAFE);
      txn(0, 0, 32'h48, 0, TO, 32'h77);
      @(negedge clk);
      chk("tie_errcnt", err_count, 1);
      tick();

      // Reset while waiting for a response; the late response must be ignored.
      drive(1, 1, 0, 32'h300, 0);
      mem_ready = 1;
      tick(); tick();
      drive(1, 0, 0, 0, 0);
      mem_ready = 0;
      tick();
      reset = 1;
      @(negedge clk);
      chk("rr_busy", busy, 0);
      tick();
      reset = 0;
      mem_rvalid = 1; mem_rdata = 32'hBAD;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rr_rvalid", {c0_rvalid, c1_rvalid}, 0);
         chk("rr_state", {busy, err_count}, 0);
         tick();
      end
      mem_rvalid = 0; mem_rdata = 0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters: the multicycle core (port 0, fetch and load/store) and the program loader/debug DMA (port 1).
- Round-robin arbitration; one outstanding transaction at a time.
- Response-timeout watchdog returns an error response when memory does not answer.
- Sits between the core/loader and the memory model or SRAM wrapper.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, cycles waited in WAIT_RSP before an error response; 0 disables the watchdog.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- c0_req  in  1  core request; held with its fields until c0_gnt
- c0_we  in  1  core write enable
- c0_addr  in  ADDR_W  core address
- c0_wdata  in  DATA_W  core write data
- c0_gnt  out  1  core request accepted by memory (1-cycle pulse)
- c0_rvalid  out  1  core response valid (1-cycle pulse)
- c0_rdata  out  DATA_W  core read data, valid with c0_rvalid
- c0_err  out  1  core response is a timeout error, valid with c0_rvalid
- c1_req, c1_we, c1_addr, c1_wdata, c1_gnt, c1_rvalid, c1_rdata, c1_err  (same as port 0)  loader port
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response; every read and write completes with exactly one
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- owner  out  1  port of the current or last transaction
- err_count  out  ERR_CNT_W  saturating count of timeouts

Behaviour:
- Reset (async): state=IDLE, prio=0 (core preferred), owner=0, timer=0, err_count=0, latched addr/wdata/we=0; all outputs 0.
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - Only one of c0_req/c1_req asserted: that port wins.
  - Both asserted: port prio wins.
  - On a win, latch the winner's we/addr/wdata, set owner, move to ISSUE next cycle.
  - mem_rvalid in IDLE is ignored (stale response after reset).
- ISSUE:
  - mem_req=1; mem_we/addr/wdata driven from the latched registers.
  - When mem_ready=1: c<owner>_gnt=1 (combinational, same cycle), prio <= ~owner, timer <= 0, go to WAIT_RSP.
  - If the owner drops its req while in ISSUE, the latched transaction still completes.
- WAIT_RSP:
  - mem_req=0. timer increments each cycle.
  - mem_rvalid=1: c<owner>_rvalid=1, c<owner>_rdata=mem_rdata, err=0, all combinational; go to IDLE.
  - TIMEOUT!=0 and timer==TIMEOUT-1 without mem_rvalid: c<owner>_rvalid=1, rdata=0, err=1; err_count += 1 (saturates at all-ones); go to IDLE.
  - mem_rvalid in the same cycle as the timeout: the normal response wins, err=0, no count.
- Non-owner gnt/rvalid/err stay 0. rdata outputs are 0 whenever the matching rvalid=0.
- Latency: request seen in IDLE at cycle N → mem_req at N+1 → gnt at N+1 if mem_ready → rvalid no earlier than N+2. Back-to-back transactions take a minimum of 3 cycles each.
- A requester holding req continuously gets at most one transaction before the other waiting port is served (fairness).
- Reset mid-transaction: immediate return to IDLE; no gnt/rvalid is generated for the aborted transaction.

Test Plan:
- Single core read: c0_req, addr=0x10; mem_ready=1 in ISSUE, mem_rvalid 2 cycles later with rdata=0xDEADBEEF → c0_gnt at cycle 1, c0_rvalid with rdata=0xDEADBEEF at cycle 3, c1_* stay 0.
- Simultaneous requests after reset: c0 read 0x0, c1 write 0x100=0x55 → core served first, loader second; mem_we=1 with addr 0x100 during the second ISSUE; prio returns to 0.
- Fairness: both req held for 4 transactions → owner sequence 0,1,0,1.
- Backpressure: mem_ready low for 5 ISSUE cycles → mem_req held, addr/wdata stable, gnt only in the cycle mem_ready=1.
- Timeout: TIMEOUT=8, no mem_rvalid → rvalid with err=1 and rdata=0 on the 8th WAIT_RSP cycle; err_count=1; the next request is then served normally. With mem_rvalid in that same cycle → err=0, err_count unchanged.
- Reset mid-WAIT_RSP, then mem_rvalid in IDLE → no rvalid on either port; busy=0, err_count=0.
